// File: rtl/ysyx_icache_if.sv
// Fetch-side and refill-bus signals of the instruction cache, bundled so the
// cache and its environment connect through a single port each.
interface ysyx_icache_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] ifu_pc;
  logic              ifu_req;
  logic [DATA_W-1:0] ifu_rdata_o;
  logic              ifu_rvalid_o;
  logic              fence_i;
  logic [ADDR_W-1:0] bus_araddr_o;
  logic              bus_arvalid_o;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_rvalid;
  logic [31:0]       hit_cnt_o;
  logic [31:0]       miss_cnt_o;

  // Cache view.
  modport slave (
    input  ifu_pc, ifu_req, fence_i, bus_rdata, bus_rvalid,
    output ifu_rdata_o, ifu_rvalid_o, bus_araddr_o, bus_arvalid_o,
           hit_cnt_o, miss_cnt_o
  );

  // Environment view: fetch unit plus bus arbiter.
  modport master (
    output ifu_pc, ifu_req, fence_i, bus_rdata, bus_rvalid,
    input  ifu_rdata_o, ifu_rvalid_o, bus_araddr_o, bus_arvalid_o,
           hit_cnt_o, miss_cnt_o
  );
endinterface

// File: rtl/ysyx_icache.sv
// Direct-mapped instruction cache, 4 words per line. Hits answer one cycle
// after the request; misses refill the whole line in beat order 0..3 and then
// answer from the freshly written line. fence_i invalidates every line.
module ysyx_icache #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SETS   = 16
) (
  input logic          clk,
  input logic          rst,
  ysyx_icache_if.slave io
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - 4 - IDX_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REFILL,
    S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              fence_seen_q, fence_seen_d;
  logic [SETS-1:0]   valid_q, valid_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [31:0]       hit_cnt_q, hit_cnt_d;
  logic [31:0]       miss_cnt_q, miss_cnt_d;

  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [DATA_W-1:0] data_mem [SETS][4];
  logic              data_we;
  logic              tag_we;

  logic [IDX_W-1:0]  pc_idx, a_idx;
  logic [TAG_W-1:0]  pc_tag, a_tag;
  logic [1:0]        pc_word, a_word;
  logic              pc_hit;

  assign pc_idx  = io.ifu_pc[4 +: IDX_W];
  assign pc_tag  = io.ifu_pc[ADDR_W-1 -: TAG_W];
  assign pc_word = io.ifu_pc[3:2];
  assign a_idx   = addr_q[4 +: IDX_W];
  assign a_tag   = addr_q[ADDR_W-1 -: TAG_W];
  assign a_word  = addr_q[3:2];
  assign pc_hit  = valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);

  // Next-state, lookup and refill control. A new request is only taken when
  // no response is showing, so responses can never be back to back.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    addr_d       = addr_q;
    fence_seen_d = fence_seen_q;
    valid_d      = valid_q;
    rvalid_d     = 1'b0;
    rdata_d      = '0;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    data_we      = 1'b0;
    tag_we       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (io.ifu_req && !rvalid_q) begin
          if (pc_hit) begin
            rvalid_d  = 1'b1;
            rdata_d   = data_mem[pc_idx][pc_word];
            hit_cnt_d = hit_cnt_q + 32'd1;
          end else begin
            addr_d       = io.ifu_pc;
            beat_d       = 2'd0;
            fence_seen_d = 1'b0;
            miss_cnt_d   = miss_cnt_q + 32'd1;
            state_d      = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        // A fence seen anywhere during the refill poisons the line.
        if (io.fence_i) fence_seen_d = 1'b1;
        if (io.bus_rvalid) begin
          data_we = 1'b1;
          beat_d  = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            tag_we  = 1'b1;
            state_d = S_RESP;
            if (!io.fence_i && !fence_seen_q) valid_d[a_idx] = 1'b1;
          end
        end
      end
      S_RESP: begin
        // The line data is readable here even if the fence kept it invalid.
        if (io.ifu_req && (io.ifu_pc == addr_q)) begin
          rvalid_d = 1'b1;
          rdata_d  = data_mem[a_idx][a_word];
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (io.fence_i) valid_d = '0;
  end

  // Control, valid bits, response and counters; reset aborts any refill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      beat_q       <= 2'd0;
      addr_q       <= '0;
      fence_seen_q <= 1'b0;
      valid_q      <= '0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      addr_q       <= addr_d;
      fence_seen_q <= fence_seen_d;
      valid_q      <= valid_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // Tag and data arrays carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (data_we) data_mem[a_idx][beat_q] <= io.bus_rdata;
    if (tag_we)  tag_mem[a_idx]          <= a_tag;
  end

  assign io.bus_arvalid_o = (state_q == S_REFILL);
  assign io.bus_araddr_o  = (state_q == S_REFILL) ? {addr_q[ADDR_W-1:4], beat_q, 2'b00} : '0;
  assign io.ifu_rvalid_o  = rvalid_q;
  assign io.ifu_rdata_o   = rdata_q;
  assign io.hit_cnt_o     = hit_cnt_q;
  assign io.miss_cnt_o    = miss_cnt_q;
endmodule

// File: tb/tb_ysyx_icache.sv
// Bench for ysyx_icache: directed scenarios followed by random fetches, all
// judged against a line-level model of a direct-mapped cache and a memory
// whose contents are a fixed function of the word address.
module tb_ysyx_icache;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SETS   = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ysyx_icache_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

  ysyx_icache #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETS(SETS)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus_if.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: which line base each set holds, plus expected counters.
  bit          m_valid [SETS];
  logic [31:0] m_line  [SETS];
  logic [31:0] m_hits;
  logic [31:0] m_misses;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic int set_of(input logic [31:0] a);
    return int'((a >> 4) % 32'(SETS));
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[set_of(a)] && (m_line[set_of(a)] == {a[31:4], 4'h0});
  endfunction

  task automatic model_clear();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One fetch. fence_beat 0..3 pulses fence_i with that refill beat, 99 pulses
  // it together with the request; drop_beat >= 0 drops ifu_req with that beat.
  task automatic fetch(input logic [31:0] pc, input int fence_beat, input int drop_beat,
                       input string name);
    bit          exp_hit, fenced, done, after_last;
    int          beats, pulses, cyc, wait_left, post, exp_pulses;
    logic [31:0] base;
    base       = {pc[31:4], 4'h0};
    exp_hit    = model_hit(pc);
    exp_pulses = (!exp_hit && drop_beat >= 0) ? 0 : 1;
    fenced     = 1'b0;
    done       = 1'b0;
    after_last = 1'b0;
    beats      = 0;
    pulses     = 0;
    cyc        = 0;
    post       = 0;
    wait_left  = $urandom_range(0, 2);
    bus_if.ifu_pc  = pc;
    bus_if.ifu_req = 1'b1;
    if (fence_beat == 99) begin
      bus_if.fence_i = 1'b1;
      fenced         = 1'b1;
    end
    while (!done) begin
      tick();
      cyc++;
      bus_if.bus_rvalid = 1'b0;
      bus_if.fence_i    = 1'b0;
      if (after_last) begin
        check({name, "/arvalid_after_beat3"}, 32'(bus_if.bus_arvalid_o), 32'd0);
        after_last = 1'b0;
      end
      if (exp_hit) check({name, "/hit_no_bus"}, 32'(bus_if.bus_arvalid_o), 32'd0);
      if (bus_if.ifu_rvalid_o) begin
        pulses++;
        check({name, "/rdata"}, bus_if.ifu_rdata_o, mem_word({pc[31:2], 2'b00}));
        if (exp_hit) check({name, "/hit_latency"}, 32'(cyc), 32'd1);
        done = 1'b1;
      end else begin
        check({name, "/rdata_idle_zero"}, bus_if.ifu_rdata_o, 32'd0);
      end
      if (bus_if.bus_arvalid_o && beats < 4) begin
        check({name, "/araddr"}, bus_if.bus_araddr_o, base + 32'(beats * 4));
        if (wait_left == 0) begin
          bus_if.bus_rvalid = 1'b1;
          bus_if.bus_rdata  = mem_word(base + 32'(beats * 4));
          if (beats == fence_beat) begin
            bus_if.fence_i = 1'b1;
            fenced         = 1'b1;
          end
          if (beats == drop_beat) bus_if.ifu_req = 1'b0;
          if (beats == 3) after_last = 1'b1;
          beats++;
          wait_left = $urandom_range(0, 2);
        end else begin
          wait_left--;
        end
      end
      if (!exp_hit && beats == 4 && !bus_if.ifu_req) post++;
      if (post >= 3) done = 1'b1;
      if (!done && cyc > 80) begin
        check({name, "/timeout_cycles"}, 32'(cyc), 32'd80);
        done = 1'b1;
      end
    end
    check({name, "/pulses"}, 32'(pulses), 32'(exp_pulses));
    check({name, "/beats"}, 32'(beats), exp_hit ? 32'd0 : 32'd4);
    if (pulses > 0) begin
      // Request still held during the response cycle: must not respond again.
      tick();
      check({name, "/no_back_to_back"}, 32'(bus_if.ifu_rvalid_o), 32'd0);
    end
    bus_if.ifu_req    = 1'b0;
    bus_if.bus_rvalid = 1'b0;
    bus_if.fence_i    = 1'b0;
    if (exp_hit) begin
      m_hits = m_hits + 32'd1;
    end else begin
      m_misses = m_misses + 32'd1;
      if (!fenced) begin
        m_valid[set_of(pc)] = 1'b1;
        m_line[set_of(pc)]  = base;
      end
    end
    if (fenced) model_clear();
    check({name, "/hit_cnt"}, bus_if.hit_cnt_o, m_hits);
    check({name, "/miss_cnt"}, bus_if.miss_cnt_o, m_misses);
    tick();
  endtask

  initial begin
    logic [31:0] rpc;
    logic [31:0] bases [3];
    int          fb, db;
    bases[0] = 32'h3000_0000;
    bases[1] = 32'h3000_0100;
    bases[2] = 32'h8000_0400;
    bus_if.ifu_pc     = '0;
    bus_if.ifu_req    = 1'b0;
    bus_if.fence_i    = 1'b0;
    bus_if.bus_rdata  = '0;
    bus_if.bus_rvalid = 1'b0;
    model_clear();
    m_hits   = '0;
    m_misses = '0;

    tick();
    tick();
    check("reset/rvalid", 32'(bus_if.ifu_rvalid_o), 32'd0);
    check("reset/rdata", bus_if.ifu_rdata_o, 32'd0);
    check("reset/arvalid", 32'(bus_if.bus_arvalid_o), 32'd0);
    check("reset/araddr", bus_if.bus_araddr_o, 32'd0);
    check("reset/hit_cnt", bus_if.hit_cnt_o, 32'd0);
    check("reset/miss_cnt", bus_if.miss_cnt_o, 32'd0);
    #2 rst = 1'b1;
    tick();

    fetch(32'h3000_0004, -1, -1, "cold_miss");
    fetch(32'h3000_0008, -1, -1, "hit_after_refill");
    fetch(32'h3000_0100, -1, -1, "conflict_replace");
    fetch(32'h3000_0000, -1, -1, "conflict_again");
    fetch(32'h3000_0040, 2, -1, "fence_beat2");
    fetch(32'h3000_0040, -1, -1, "fence_beat2_remiss");
    fetch(32'h3000_0080, -1, 0, "drop_after_beat0");
    fetch(32'h3000_0084, -1, -1, "drop_line_hits");
    fetch(32'h3000_0088, 99, -1, "fence_with_hit");
    fetch(32'h3000_0088, -1, -1, "fence_with_hit_remiss");

    // Reset while waiting on beat 1 of a refill.
    bus_if.ifu_pc  = 32'h3000_0004;
    bus_if.ifu_req = 1'b1;
    tick();
    check("rst_mid/arvalid_beat0", 32'(bus_if.bus_arvalid_o), 32'd1);
    check("rst_mid/araddr_beat0", bus_if.bus_araddr_o, 32'h3000_0000);
    bus_if.bus_rvalid = 1'b1;
    bus_if.bus_rdata  = mem_word(32'h3000_0000);
    tick();
    bus_if.bus_rvalid = 1'b0;
    check("rst_mid/araddr_beat1", bus_if.bus_araddr_o, 32'h3000_0004);
    #1 rst = 1'b0;
    #1;
    check("rst_mid/arvalid_dropped", 32'(bus_if.bus_arvalid_o), 32'd0);
    check("rst_mid/hit_cnt", bus_if.hit_cnt_o, 32'd0);
    check("rst_mid/miss_cnt", bus_if.miss_cnt_o, 32'd0);
    check("rst_mid/rvalid", 32'(bus_if.ifu_rvalid_o), 32'd0);
    bus_if.ifu_req = 1'b0;
    model_clear();
    m_hits   = '0;
    m_misses = '0;
    tick();
    tick();
    #2 rst = 1'b1;
    tick();
    fetch(32'h3000_0004, -1, -1, "rst_mid_remiss");

    // Random traffic over a few conflicting regions.
    for (int i = 0; i < 60; i++) begin
      rpc = bases[$urandom_range(0, 2)] + 32'($urandom_range(0, 127) * 4);
      fb  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      db  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
      fetch(rpc, fb, db, "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ysyx_icache.md
YSYX_ICACHE -- requirements
Module: ysyx_icache

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning instruction word width.
REQ-003 SHALL have parameter SETS, default 16, meaning number of direct-mapped lines; each line is 4 words (16 bytes).
REQ-004 SHALL have ports clk, input, 1, the single clock; rising edge only.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have ports ifu_pc (input, ADDR_W, fetch address) and ifu_req (input, 1, fetch request, held stable until ifu_rvalid_o).
REQ-007 SHALL have ports ifu_rdata_o (output, DATA_W, instruction) and ifu_rvalid_o (output, 1, one-cycle response pulse).
REQ-008 SHALL have port fence_i, input, 1, invalidate-all pulse.
REQ-009 SHALL have ports bus_araddr_o (output, ADDR_W) and bus_arvalid_o (output, 1), driving the arbiter ifu_araddr/ifu_arvalid.
REQ-010 SHALL have ports bus_rdata (input, DATA_W) and bus_rvalid (input, 1), fed from the arbiter ifu_rdata_o/ifu_rvalid_o.
REQ-011 SHALL have ports hit_cnt_o and miss_cnt_o, output, 32, performance counters.

Function
REQ-012 SHALL split addresses as offset = addr[3:0], word select = addr[3:2], index = addr[3+log2(SETS):4], tag = remaining upper bits.
REQ-013 SHALL hold per line a valid bit, a tag, and 4 data words; a hit is valid[index] && tag match.
REQ-014 SHALL implement states IDLE, REFILL, RESP.
REQ-015 In IDLE with ifu_req=1 and hit: SHALL drive ifu_rvalid_o=1 with the selected word on the next cycle (1-cycle hit latency), increment hit_cnt_o, stay IDLE.
REQ-016 In IDLE with ifu_req=1 and miss: SHALL latch ifu_pc, clear the beat counter, increment miss_cnt_o, go to REFILL.
REQ-017 In REFILL: SHALL drive bus_arvalid_o=1, bus_araddr_o = {line base, beat, 2'b00}, held constant until bus_rvalid=1.
REQ-018 On each bus_rvalid in REFILL: SHALL write bus_rdata into word[beat] and increment beat; beats are issued in order 0,1,2,3.
REQ-019 bus_arvalid_o SHALL be 0 in the cycle after the beat-3 bus_rvalid; on that beat the tag is written, valid set, and state goes to RESP.
REQ-020 In RESP: if ifu_req=1 and ifu_pc equals the latched address, SHALL pulse ifu_rvalid_o with the requested word; otherwise no pulse. Either way, SHALL return to IDLE next cycle.
REQ-021 ifu_req deasserted during REFILL: refill SHALL run to completion (a bus read is never abandoned) and install the line.
REQ-022 fence_i SHALL clear all valid bits on the next edge in any state; if asserted during REFILL, the line being filled SHALL NOT be marked valid, but RESP still delivers the refilled word.
REQ-023 fence_i coincident with an IDLE hit: the hit response SHALL still be delivered; subsequent lookups miss.
REQ-024 ifu_rvalid_o SHALL never be asserted in two consecutive cycles; ifu_rdata_o SHALL be 0 when ifu_rvalid_o=0.
REQ-025 Counters SHALL wrap modulo 2^32 and not saturate.
REQ-026 bus_arvalid_o SHALL be 0 in IDLE and RESP.

Reset
REQ-027 On rst low, SHALL immediately (asynchronously) go to IDLE, clear all valid bits, beat counter, both counters, bus_arvalid_o, bus_araddr_o, ifu_rvalid_o, ifu_rdata_o to 0.
REQ-028 Reset asserted mid-REFILL SHALL drop bus_arvalid_o without waiting for bus_rvalid and leave the line invalid.
REQ-029 Data and tag arrays need no reset.

Verification
REQ-030 Cold miss: ifu_req, ifu_pc=0x30000004 -> bus reads 0x30000000, 0x30000004, 0x30000008, 0x3000000C in order; one ifu_rvalid_o carrying word 1; miss_cnt_o=1.
REQ-031 Hit after refill: ifu_pc=0x30000008 -> ifu_rvalid_o next cycle with word 2, bus_arvalid_o stays 0, hit_cnt_o=1.
REQ-032 Conflict: 0x30000100 (SETS=16, index 0) -> miss and replace; then 0x30000000 -> miss again; miss_cnt_o=3.
REQ-033 fence_i during beat 2 of refill -> RESP still delivers the word; re-requesting the same pc misses.
REQ-034 ifu_req dropped after beat 0 -> no ifu_rvalid_o pulse; a later request to the same line hits.
REQ-035 rst low during beat 1 with bus_rvalid=0 -> bus_arvalid_o=0 immediately, counters 0; after release the same pc misses.
